// File: rtl/cpu_ctrl.sv
// VeriRISC instruction sequencer: eight-phase counter plus opcode/zero decode of datapath strobes.
// Optional single-step restart from halt is built when CTRL_SINGLE_STEP_EN is defined.
module cpu_ctrl #(
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             sel,
    output logic             rd,
    output logic             wr,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase
);

    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    logic [2:0] phase_q, phase_d;
    logic       halt_q, halt_d;
    logic       aluop;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // Halt is captured on the edge leaving phase 4, so the counter lands on 5 and sticks there.
    always_comb begin
        phase_d = phase_q + 3'd1;
        halt_d  = halt_q;
        if (halt_q) begin
            phase_d = phase_q;
`ifdef CTRL_SINGLE_STEP_EN
            if (step) begin
                halt_d  = 1'b0;
                phase_d = PH_INST_ADDR;
            end
`endif
        end else if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (phase_q)
            PH_INST_ADDR: sel = 1'b1;
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: rd = aluop;
            PH_ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            default: ;
        endcase
        // Halted state masks the phase-5 decode; reset masks everything.
        if (halt_q) begin
            {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e} = '0;
            halt = 1'b1;
        end
        if (!rst_n) begin
            {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt} = '0;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed vector bench for cpu_ctrl: per-cycle expected phase and strobe word {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}.
module tb_cpu_ctrl;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = STO;
    logic       zero = 1'b0;
    logic       step = 1'b0;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;

    int nvec = 0;
    int nerr = 0;

    cpu_ctrl #(.OPC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
        .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       r;
        logic [2:0] o;
        logic       z;
        logic [2:0] ph;
        logic [8:0] ex;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic r, input logic [2:0] o, input logic z,
                       input logic [2:0] ph, input logic [8:0] ex);
        vec_t v;
        v.nm = nm; v.r = r; v.o = o; v.z = z; v.ph = ph; v.ex = ex;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input string nm, input logic r, input logic [2:0] o, input logic z,
                         input logic st, input logic [2:0] eph, input logic [8:0] ex);
        logic [8:0] got;
        @(negedge clk);
        rst_n = r; opcode = o; zero = z; step = st;
        #1;
        got = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
        nvec++;
        if (got !== ex || phase !== eph) begin
            nerr++;
            $display("FAIL %s: phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                     nm, phase, got, eph, ex);
        end
    endtask

    initial begin
        // STO up to phase 6, then reset held 3 cycles
        add("sto_p0", 1, STO, 0, 0, 9'b100000000);
        add("sto_p1", 1, STO, 0, 1, 9'b110000000);
        add("sto_p2", 1, STO, 0, 2, 9'b110100000);
        add("sto_p3", 1, STO, 0, 3, 9'b110100000);
        add("sto_p4", 1, STO, 0, 4, 9'b000000100);
        add("sto_p5", 1, STO, 0, 5, 9'b000000000);
        add("rst_a",  0, STO, 0, 6, 9'b000000000);
        add("rst_b",  0, STO, 0, 0, 9'b000000000);
        add("rst_c",  0, STO, 0, 0, 9'b000000000);
        // ADD, zero=0
        add("add_p0", 1, ADD, 0, 0, 9'b100000000);
        add("add_p1", 1, ADD, 0, 1, 9'b110000000);
        add("add_p2", 1, ADD, 0, 2, 9'b110100000);
        add("add_p3", 1, ADD, 0, 3, 9'b110100000);
        add("add_p4", 1, ADD, 0, 4, 9'b000000100);
        add("add_p5", 1, ADD, 0, 5, 9'b010000000);
        add("add_p6", 1, ADD, 0, 6, 9'b010000000);
        add("add_p7", 1, ADD, 0, 7, 9'b010010000);
        // SKZ, zero=1
        add("skz1_p0", 1, SKZ, 1, 0, 9'b100000000);
        add("skz1_p1", 1, SKZ, 1, 1, 9'b110000000);
        add("skz1_p2", 1, SKZ, 1, 2, 9'b110100000);
        add("skz1_p3", 1, SKZ, 1, 3, 9'b110100000);
        add("skz1_p4", 1, SKZ, 1, 4, 9'b000000100);
        add("skz1_p5", 1, SKZ, 1, 5, 9'b000000000);
        add("skz1_p6", 1, SKZ, 1, 6, 9'b000000100);
        add("skz1_p7", 1, SKZ, 1, 7, 9'b000000000);
        // SKZ, zero=0 in phase 6 only; zero=1 elsewhere must be ignored
        add("skz0_p0", 1, SKZ, 1, 0, 9'b100000000);
        add("skz0_p1", 1, SKZ, 1, 1, 9'b110000000);
        add("skz0_p2", 1, SKZ, 1, 2, 9'b110100000);
        add("skz0_p3", 1, SKZ, 1, 3, 9'b110100000);
        add("skz0_p4", 1, SKZ, 1, 4, 9'b000000100);
        add("skz0_p5", 1, SKZ, 1, 5, 9'b000000000);
        add("skz0_p6", 1, SKZ, 0, 6, 9'b000000000);
        add("skz0_p7", 1, SKZ, 1, 7, 9'b000000000);
        // STO
        add("st_p0", 1, STO, 0, 0, 9'b100000000);
        add("st_p1", 1, STO, 0, 1, 9'b110000000);
        add("st_p2", 1, STO, 0, 2, 9'b110100000);
        add("st_p3", 1, STO, 0, 3, 9'b110100000);
        add("st_p4", 1, STO, 0, 4, 9'b000000100);
        add("st_p5", 1, STO, 0, 5, 9'b000000000);
        add("st_p6", 1, STO, 0, 6, 9'b000000010);
        add("st_p7", 1, STO, 0, 7, 9'b001000010);
        // JMP
        add("jmp_p0", 1, JMP, 0, 0, 9'b100000000);
        add("jmp_p1", 1, JMP, 0, 1, 9'b110000000);
        add("jmp_p2", 1, JMP, 0, 2, 9'b110100000);
        add("jmp_p3", 1, JMP, 0, 3, 9'b110100000);
        add("jmp_p4", 1, JMP, 0, 4, 9'b000000100);
        add("jmp_p5", 1, JMP, 0, 5, 9'b000000000);
        add("jmp_p6", 1, JMP, 0, 6, 9'b000001000);
        add("jmp_p7", 1, JMP, 0, 7, 9'b000001000);
        // HLT up to the halting phase
        add("hlt_p0", 1, HLT, 0, 0, 9'b100000000);
        add("hlt_p1", 1, HLT, 0, 1, 9'b110000000);
        add("hlt_p2", 1, HLT, 0, 2, 9'b110100000);
        add("hlt_p3", 1, HLT, 0, 3, 9'b110100000);
        add("hlt_p4", 1, HLT, 0, 4, 9'b000000101);

        // Initial reset to a known state, then walk the table
        rst_n = 1'b0;
        opcode = STO;
        repeat (2) @(posedge clk);
        foreach (tbl[i])
            apply(tbl[i].nm, tbl[i].r, tbl[i].o, tbl[i].z, 1'b0, tbl[i].ph, tbl[i].ex);

        // Sticky halt: 20 cycles at phase 5, opcode and zero wiggled
        for (int i = 0; i < 20; i++)
            apply("halted", 1, 3'(i), i[0], 1'b0, 5, 9'b000000001);

`ifdef CTRL_SINGLE_STEP_EN
        apply("step_pulse", 1, ADD, 0, 1'b1, 5, 9'b000000001);
        apply("ss_add_p0", 1, ADD, 0, 1'b0, 0, 9'b100000000);
        apply("ss_add_p1", 1, ADD, 0, 1'b0, 1, 9'b110000000);
        apply("ss_add_p2", 1, ADD, 0, 1'b1, 2, 9'b110100000);
        apply("ss_add_p3", 1, ADD, 0, 1'b0, 3, 9'b110100000);
        apply("ss_add_p4", 1, ADD, 0, 1'b0, 4, 9'b000000100);
        apply("ss_add_p5", 1, ADD, 0, 1'b0, 5, 9'b010000000);
        apply("ss_add_p6", 1, ADD, 0, 1'b0, 6, 9'b010000000);
        apply("ss_add_p7", 1, ADD, 0, 1'b0, 7, 9'b010010000);
        apply("ss_hlt_p0", 1, HLT, 0, 1'b0, 0, 9'b100000000);
        apply("ss_hlt_p1", 1, HLT, 0, 1'b0, 1, 9'b110000000);
        apply("ss_hlt_p2", 1, HLT, 0, 1'b0, 2, 9'b110100000);
        apply("ss_hlt_p3", 1, HLT, 0, 1'b0, 3, 9'b110100000);
        apply("ss_hlt_p4", 1, HLT, 0, 1'b0, 4, 9'b000000101);
        apply("ss_rehalt_a", 1, ADD, 0, 1'b0, 5, 9'b000000001);
        apply("ss_rehalt_b", 1, ADD, 0, 1'b0, 5, 9'b000000001);
`endif

        // Reset while halted
        apply("rst_halt", 0, STO, 0, 1'b0, 5, 9'b000000000);
        apply("post_rst_p0", 1, STO, 0, 1'b0, 0, 9'b100000000);
        apply("post_rst_p1", 1, STO, 0, 1'b0, 1, 9'b110000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction sequencer for the VeriRISC core. A 3-bit phase counter steps every instruction through eight fixed phases. Each phase is decoded with the instruction-register opcode and the ALU `a_is_zero` flag to produce the datapath strobes: memory address select, memory read/write, IR/PC/accumulator loads, PC increment, data-bus enable and halt. It sits between the instruction register, the ALU and the memory/PC/accumulator registers.

## Interface
Parameters:
- `OPC_W`, 3: opcode width. Fixed encoding:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `opcode` input 3: current IR opcode, stable from phase 3 onward.
- `zero` input 1: ALU `a_is_zero`.
- `sel` output 1: 1 = PC drives memory address, 0 = IR operand.
- `rd` output 1: memory read.
- `wr` output 1: memory write.
- `ld_ir` output 1: load instruction register.
- `ld_ac` output 1: load accumulator from ALU.
- `ld_pc` output 1: load PC from IR operand.
- `inc_pc` output 1: increment PC.
- `data_e` output 1: accumulator drives data bus.
- `halt` output 1: processor halted.
- `phase` output 3: current phase, for debug.
- `step` input 1: single-step request. Present only with `CTRL_SINGLE_STEP_EN`.

## Operation
- Phase counter: registered, 0→7, wraps 7→0, advances every cycle unless halted.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes are decoded combinationally from the registered `phase`, `opcode` and `zero`. Each is 0 unless listed for the phase:
  - 0 INST_ADDR: `sel`.
  - 1 INST_FETCH: `sel`, `rd`.
  - 2 INST_LOAD: `sel`, `rd`, `ld_ir`.
  - 3 IDLE: `sel`, `rd`, `ld_ir`.
  - 4 OP_ADDR: `inc_pc`; `halt` if HLT.
  - 5 OP_FETCH: `rd` if ALUOP.
  - 6 ALU_OP: `rd` if ALUOP; `inc_pc` if SKZ and `zero`; `ld_pc` if JMP; `data_e` if STO.
  - 7 STORE: `rd` and `ld_ac` if ALUOP; `ld_pc` if JMP; `wr` and `data_e` if STO.
- Halt register:
  - Set on the edge that ends phase 4 when opcode = HLT.
  - Phase then advances to 5 and freezes.
  - While halted: `halt`=1; all other strobes 0; `phase` holds 5.
- Opcode decoding is exhaustive. No illegal opcodes.

## Timing
- Reset (`rst_n` low at a rising edge):
  - `phase`=0, halt register=0.
  - While `rst_n` is low, all strobe outputs are forced to 0, including `sel`.
- First edge after `rst_n` returns high: `phase` 0→1.
- Instruction latency: exactly 8 cycles per instruction, no stalls.
- PC increments once in phase 4; SKZ with `zero`=1 increments a second time in phase 6.
- `zero` is sampled combinationally in phase 6 only. Changes in other phases have no effect.
- Reset has priority over everything, in any phase or while halted: next cycle is phase 0, halt register cleared, no strobe issued.
- HLT already held in phase 4: `halt` is high in phase 4 and remains high continuously thereafter.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - `step` port exists.
  - `step`=1 sampled while halted: the halt register clears and `phase` goes to 0 on that edge.
  - One instruction then executes from the already-incremented PC. If that instruction is HLT, the controller re-halts.
  - `step` while not halted is ignored.
- `CTRL_SINGLE_STEP_EN` undefined:
  - No `step` port.
  - Halt is sticky until `rst_n` is asserted.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles in mid-phase 6 with opcode=STO → `phase`=0 and all strobes 0. After release, phases 1..7,0 follow, with `sel`=1 in phases 0–3.
- ADD, `zero`=0: `rd`=1 in phases 5–7; `ld_ac`=1 only in phase 7; `inc_pc`=1 only in phase 4; `wr`, `ld_pc`, `data_e` never set.
- SKZ: with `zero`=1 → `inc_pc` high in phases 4 and 6. With `zero`=0 → `inc_pc` high in phase 4 only.
- STO then JMP:
  - STO: `data_e`=1 in phases 6–7; `wr`=1 only in phase 7.
  - JMP: `ld_pc`=1 in phases 6–7; `rd`=0 in phases 5–7.
- HLT: `halt`=1 in phase 4, then `phase` holds 5 and `halt` stays 1 for 20 cycles with all other strobes 0.
- `CTRL_SINGLE_STEP_EN`:
  - While halted, a 1-cycle `step` pulse → `phase`=0 next cycle; one full 8-phase instruction runs (opcode=ADD, `ld_ac` in phase 7), then phases continue.
  - With opcode=HLT in the stepped instruction → the controller re-halts at phase 5.
